unidade_controle_exp7: RTL and testbench
========================================

Name: unidade_controle_exp7

Overview:
- Moore FSM that sequences fluxo_dados_exp6 for the challenge version of the memory game.
- Drives every counter, timer, register, memory-write and LED-select control of the datapath, and consumes its status flags.
- Game flow: show the first stored item, have the player repeat the sequence each round, let the player append one new item per round, and finish on win, wrong play or timeout.
- Sits directly above the datapath inside the top-level circuito_exp7.

Parameters:
- TIMEOUT_EN, default 1: 1 = fimT ends the game with timeout; 0 = fimT is ignored.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low; forces state inicial
- iniciar  in  1  level; starts or restarts the game from inicial or any fim_* state
- fimRod  in  1  round counter terminal count (rodada = 15)
- fimT  in  1  play timeout reached (5000 cycles)
- fimP  in  1  first-item display time elapsed (2000 cycles)
- igual  in  1  registered play equals memory data
- enderecoIgualRodada  in  1  address counter equals round counter
- jogada_feita  in  1  one-cycle pulse per new key play
- zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraP, contaP, zeraR, registraR  out  1 each  datapath controls
- we  out  1  memory write enable
- sinal_led  out  1  LED source: 1 = memory data, 0 = registered keys
- pronto  out  1  game finished, any outcome
- ganhou  out  1  finished by completing round 15
- perdeu  out  1  finished by a wrong play
- timeout  out  1  finished by fimT
- db_estado  out  5  current state code

Behaviour:
- Moore machine: all outputs decode from the current state only; next state registers on the rising clock edge.
- Reset: when reset = 0 at a clock edge, state becomes inicial (code 0). All outputs are 0 in inicial. Reset overrides every other input in every state.
- States and codes:
  - inicial (0): idle, all outputs 0. iniciar = 1 -> preparacao.
  - preparacao (1): assert zeraE, zeraRod, zeraR, zeraT, zeraP. Always -> mostra_primeira.
  - mostra_primeira (2): assert sinal_led and contaP. fimP = 1 -> inicio_rodada; otherwise stay.
  - inicio_rodada (3): assert zeraE and zeraT. Always -> espera_jogada.
  - espera_jogada (4): assert contaT.
    - jogada_feita = 1 -> registra. jogada_feita has priority if it coincides with fimT.
    - Else fimT = 1 and TIMEOUT_EN = 1 -> fim_timeout.
  - registra (5): assert registraR and zeraT. Always -> comparacao.
  - comparacao (6): no outputs asserted; igual reflects the registered value.
    - igual = 0 -> fim_errou.
    - Else enderecoIgualRodada = 1 -> ultima_rodada.
    - Else -> proximo_endereco.
  - proximo_endereco (7): assert contaE. Always -> espera_jogada.
  - ultima_rodada (8): no outputs asserted.
    - fimRod = 1 -> fim_acertou.
    - Else -> incrementa_endereco.
  - incrementa_endereco (9): assert contaE and zeraT. Always -> espera_escrita.
  - espera_escrita (10): assert contaT. Same transition rules as espera_jogada, but jogada_feita -> registra_escrita.
  - registra_escrita (11): assert registraR. Always -> escreve.
  - escreve (12): assert we for exactly one cycle. Always -> proxima_rodada.
  - proxima_rodada (13): assert contaRod. Always -> inicio_rodada.
  - fim_acertou (14): pronto = 1, ganhou = 1, sinal_led = 0.
  - fim_errou (15): pronto = 1, perdeu = 1.
  - fim_timeout (16): pronto = 1, timeout = 1.
  - In all three fim_* states, iniciar = 1 -> preparacao; otherwise stay.
- Unused codes 17–31 -> inicial on the next edge.
- Exactly one datapath control pulse per play, so the address and round counters never double-count.
- Minimum round latency: a correct play is judged 2 cycles after the jogada_feita pulse.
- Restart: iniciar asserted while in any fim_* state restarts the game. iniciar is ignored while a game is in progress.
- db_estado = state code, zero-extended to 5 bits.

Decomposition:
- Shared package unidade_controle_pkg holds the 5-bit state localparams (inicial = 5'd0 … fim_timeout = 5'd16).
- The package also holds DB_ESTADO_W = 5.
- Single module containing the state register, next-state logic and output decoder. No sub-module is needed.
- Seven-segment display of db_estado stays in the top level.

Test Plan:
- Reset then start: reset low for 2 cycles, then high; iniciar = 1 for 1 cycle -> db_estado = 0, then 1, then 2. sinal_led = 1 until fimP is forced, then db_estado = 3.
- Round 0 correct play plus write: igual = 1, enderecoIgualRodada = 1, fimRod = 0, pulse jogada_feita -> states 4→5→6→8→9→10. Second pulse -> 11→12 with we = 1 for exactly 1 cycle, then 13 with contaRod = 1, then 3.
- Wrong play: in espera_jogada, igual = 0, pulse jogada_feita -> state 15 after 2 cycles; pronto = 1, perdeu = 1, ganhou = 0, timeout = 0.
- Timeout: hold fimT = 1 in espera_escrita -> state 16, timeout = 1. Same test with TIMEOUT_EN = 0 -> stays in 10.
- Win: igual = 1, enderecoIgualRodada = 1, fimRod = 1, pulse jogada_feita -> state 14, ganhou = 1. Then iniciar = 1 -> state 1.
- Mid-game reset: reset = 0 in state 12 -> state 0 next edge, we = 0. Also jogada_feita and fimT both asserted in state 4 -> state 5.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// ---------------------------------------------------------------------------
// unidade_controle_pkg
//   Shared definitions for the memory-game control unit (unidade_controle_exp7):
//   the 5-bit state codes, the width of the db_estado debug port, the bundle
//   of datapath control outputs and the state -> outputs decoder.
// ---------------------------------------------------------------------------
package unidade_controle_pkg;

  localparam int DB_ESTADO_W = 5;

  typedef enum logic [DB_ESTADO_W-1:0] {
    INICIAL             = 5'd0,
    PREPARACAO          = 5'd1,
    MOSTRA_PRIMEIRA     = 5'd2,
    INICIO_RODADA       = 5'd3,
    ESPERA_JOGADA       = 5'd4,
    REGISTRA            = 5'd5,
    COMPARACAO          = 5'd6,
    PROXIMO_ENDERECO    = 5'd7,
    ULTIMA_RODADA       = 5'd8,
    INCREMENTA_ENDERECO = 5'd9,
    ESPERA_ESCRITA      = 5'd10,
    REGISTRA_ESCRITA    = 5'd11,
    ESCREVE             = 5'd12,
    PROXIMA_RODADA      = 5'd13,
    FIM_ACERTOU         = 5'd14,
    FIM_ERROU           = 5'd15,
    FIM_TIMEOUT         = 5'd16
  } estado_t;

  // All control outputs of the FSM, registered together with the state.
  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraRod;
    logic contaRod;
    logic zeraT;
    logic contaT;
    logic zeraP;
    logic contaP;
    logic zeraR;
    logic registraR;
    logic we;
    logic sinal_led;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic timeout;
  } ctrl_t;

  // Moore output decode: what the datapath sees while sitting in state st.
  function automatic ctrl_t decodifica_saidas(input estado_t st);
    ctrl_t c;
    c = '0;
    case (st)
      PREPARACAO: begin
        c.zeraE   = 1'b1;
        c.zeraRod = 1'b1;
        c.zeraR   = 1'b1;
        c.zeraT   = 1'b1;
        c.zeraP   = 1'b1;
      end
      MOSTRA_PRIMEIRA: begin
        c.sinal_led = 1'b1;
        c.contaP    = 1'b1;
      end
      INICIO_RODADA: begin
        c.zeraE = 1'b1;
        c.zeraT = 1'b1;
      end
      ESPERA_JOGADA:       c.contaT = 1'b1;
      REGISTRA: begin
        c.registraR = 1'b1;
        c.zeraT     = 1'b1;
      end
      PROXIMO_ENDERECO:    c.contaE = 1'b1;
      INCREMENTA_ENDERECO: begin
        c.contaE = 1'b1;
        c.zeraT  = 1'b1;
      end
      ESPERA_ESCRITA:      c.contaT    = 1'b1;
      REGISTRA_ESCRITA:    c.registraR = 1'b1;
      ESCREVE:             c.we        = 1'b1;
      PROXIMA_RODADA:      c.contaRod  = 1'b1;
      FIM_ACERTOU: begin
        c.pronto = 1'b1;
        c.ganhou = 1'b1;
      end
      FIM_ERROU: begin
        c.pronto = 1'b1;
        c.perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        c.pronto  = 1'b1;
        c.timeout = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidade_controle_exp7.sv
// ---------------------------------------------------------------------------
// unidade_controle_exp7
//   Moore FSM sequencing fluxo_dados_exp6 for the challenge memory game:
//   shows the first stored item, lets the player repeat the sequence each
//   round, appends one new item per round and ends on win, error or timeout.
//
// Parameters
//   TIMEOUT_EN : 1 = fimT ends the game (fim_timeout), 0 = fimT ignored
//
// Ports
//   clock, reset (sync, active-low)       clocking / reset
//   iniciar                               start / restart request (level)
//   fimRod, fimT, fimP, igual,
//   enderecoIgualRodada, jogada_feita     datapath status flags
//   zeraE..registraR, we, sinal_led       datapath controls
//   pronto, ganhou, perdeu, timeout       game outcome
//   db_estado                             current state code
//
// Outputs are decoded from the next state and registered alongside it, so
// they are glitch-free yet still a pure function of the current state.
// ---------------------------------------------------------------------------
module unidade_controle_exp7
  import unidade_controle_pkg::*;
#(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   fimRod,
  input  logic                   fimT,
  input  logic                   fimP,
  input  logic                   igual,
  input  logic                   enderecoIgualRodada,
  input  logic                   jogada_feita,
  output logic                   zeraE,
  output logic                   contaE,
  output logic                   zeraRod,
  output logic                   contaRod,
  output logic                   zeraT,
  output logic                   contaT,
  output logic                   zeraP,
  output logic                   contaP,
  output logic                   zeraR,
  output logic                   registraR,
  output logic                   we,
  output logic                   sinal_led,
  output logic                   pronto,
  output logic                   ganhou,
  output logic                   perdeu,
  output logic                   timeout,
  output logic [DB_ESTADO_W-1:0] db_estado
);

  estado_t estado_q, estado_d;
  ctrl_t   saida_q, saida_d;

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:             if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:          estado_d = MOSTRA_PRIMEIRA;
      MOSTRA_PRIMEIRA:     if (fimP) estado_d = INICIO_RODADA;
      INICIO_RODADA:       estado_d = ESPERA_JOGADA;
      // A play arriving on the same cycle as the timeout still counts.
      ESPERA_JOGADA: begin
        if (jogada_feita)             estado_d = REGISTRA;
        else if (fimT && TIMEOUT_EN)  estado_d = FIM_TIMEOUT;
      end
      REGISTRA:            estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                   estado_d = FIM_ERROU;
        else if (enderecoIgualRodada) estado_d = ULTIMA_RODADA;
        else                          estado_d = PROXIMO_ENDERECO;
      end
      PROXIMO_ENDERECO:    estado_d = ESPERA_JOGADA;
      ULTIMA_RODADA:       estado_d = fimRod ? FIM_ACERTOU : INCREMENTA_ENDERECO;
      INCREMENTA_ENDERECO: estado_d = ESPERA_ESCRITA;
      ESPERA_ESCRITA: begin
        if (jogada_feita)             estado_d = REGISTRA_ESCRITA;
        else if (fimT && TIMEOUT_EN)  estado_d = FIM_TIMEOUT;
      end
      REGISTRA_ESCRITA:    estado_d = ESCREVE;
      ESCREVE:             estado_d = PROXIMA_RODADA;
      PROXIMA_RODADA:      estado_d = INICIO_RODADA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT:         if (iniciar) estado_d = PREPARACAO;
      // Unreachable codes recover to idle.
      default:             estado_d = INICIAL;
    endcase
  end

  always_comb begin
    saida_d = decodifica_saidas(estado_d);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= INICIAL;
      saida_q  <= '0;
    end else begin
      estado_q <= estado_d;
      saida_q  <= saida_d;
    end
  end

  assign zeraE     = saida_q.zeraE;
  assign contaE    = saida_q.contaE;
  assign zeraRod   = saida_q.zeraRod;
  assign contaRod  = saida_q.contaRod;
  assign zeraT     = saida_q.zeraT;
  assign contaT    = saida_q.contaT;
  assign zeraP     = saida_q.zeraP;
  assign contaP    = saida_q.contaP;
  assign zeraR     = saida_q.zeraR;
  assign registraR = saida_q.registraR;
  assign we        = saida_q.we;
  assign sinal_led = saida_q.sinal_led;
  assign pronto    = saida_q.pronto;
  assign ganhou    = saida_q.ganhou;
  assign perdeu    = saida_q.perdeu;
  assign timeout   = saida_q.timeout;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_exp7.sv
// ---------------------------------------------------------------------------
// tb_unidade_controle_exp7
//   Two instances (TIMEOUT_EN = 1 and 0) receive identical stimulus. A
//   behavioural model of the game flow predicts state and outputs of each;
//   a negedge process compares them every cycle, and directed literal checks
//   pin key points of the flow.
// ---------------------------------------------------------------------------
module tb_unidade_controle_exp7;

  logic clock = 1'b0;
  logic reset, iniciar, fimRod, fimT, fimP, igual, enderecoIgualRodada, jogada_feita;

  logic [15:0] o1, o2;
  logic [4:0]  db1, db2;

  int checks = 0;
  int errors = 0;
  int m1 = 0;
  int m2 = 0;
  bit started = 0;

  always #5 clock = ~clock;

  // Output vector bit positions
  localparam logic [15:0] ZE = 16'h8000, CE = 16'h4000, ZRO = 16'h2000, CRO = 16'h1000,
                          ZT = 16'h0800, CT = 16'h0400, ZP = 16'h0200, CP = 16'h0100,
                          ZR = 16'h0080, RR = 16'h0040, WE = 16'h0020, SL = 16'h0010,
                          PR = 16'h0008, GA = 16'h0004, PE = 16'h0002, TO = 16'h0001;

  unidade_controle_exp7 #(.TIMEOUT_EN(1'b1)) u_dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimRod(fimRod), .fimT(fimT),
    .fimP(fimP), .igual(igual), .enderecoIgualRodada(enderecoIgualRodada),
    .jogada_feita(jogada_feita),
    .zeraE(o1[15]), .contaE(o1[14]), .zeraRod(o1[13]), .contaRod(o1[12]),
    .zeraT(o1[11]), .contaT(o1[10]), .zeraP(o1[9]), .contaP(o1[8]),
    .zeraR(o1[7]), .registraR(o1[6]), .we(o1[5]), .sinal_led(o1[4]),
    .pronto(o1[3]), .ganhou(o1[2]), .perdeu(o1[1]), .timeout(o1[0]),
    .db_estado(db1)
  );

  unidade_controle_exp7 #(.TIMEOUT_EN(1'b0)) u_dut_nt (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimRod(fimRod), .fimT(fimT),
    .fimP(fimP), .igual(igual), .enderecoIgualRodada(enderecoIgualRodada),
    .jogada_feita(jogada_feita),
    .zeraE(o2[15]), .contaE(o2[14]), .zeraRod(o2[13]), .contaRod(o2[12]),
    .zeraT(o2[11]), .contaT(o2[10]), .zeraP(o2[9]), .contaP(o2[8]),
    .zeraR(o2[7]), .registraR(o2[6]), .we(o2[5]), .sinal_led(o2[4]),
    .pronto(o2[3]), .ganhou(o2[2]), .perdeu(o2[1]), .timeout(o2[0]),
    .db_estado(db2)
  );

  // Expected outputs per state, taken from the game description.
  function automatic logic [15:0] expected_outs(input int s);
    case (s)
      1:  return ZE | ZRO | ZR | ZT | ZP;
      2:  return SL | CP;
      3:  return ZE | ZT;
      4:  return CT;
      5:  return RR | ZT;
      7:  return CE;
      9:  return CE | ZT;
      10: return CT;
      11: return RR;
      12: return WE;
      13: return CRO;
      14: return PR | GA;
      15: return PR | PE;
      16: return PR | TO;
      default: return 16'h0000;
    endcase
  endfunction

  // Game-flow model: where the game goes next from state s.
  function automatic int model_next(input int s, input bit te);
    if (!reset) return 0;
    case (s)
      0:  return iniciar ? 1 : 0;
      1:  return 2;
      2:  return fimP ? 3 : 2;
      3:  return 4;
      4:  return jogada_feita ? 5 : ((fimT && te) ? 16 : 4);
      5:  return 6;
      6:  return !igual ? 15 : (enderecoIgualRodada ? 8 : 7);
      7:  return 4;
      8:  return fimRod ? 14 : 9;
      9:  return 10;
      10: return jogada_feita ? 11 : ((fimT && te) ? 16 : 10);
      11: return 12;
      12: return 13;
      13: return 3;
      14, 15, 16: return iniciar ? 1 : s;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock) begin
    m1 <= model_next(m1, 1'b1);
    m2 <= model_next(m2, 1'b0);
    started <= 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (started) begin
      checks = checks + 4;
      if (db1 !== 5'(m1)) begin
        errors++;
        $display("FAIL model_state_te1: got %0d expected %0d at %0t", db1, m1, $time);
      end
      if (o1 !== expected_outs(m1)) begin
        errors++;
        $display("FAIL model_outs_te1: got %h expected %h (state %0d) at %0t", o1, expected_outs(m1), m1, $time);
      end
      if (db2 !== 5'(m2)) begin
        errors++;
        $display("FAIL model_state_te0: got %0d expected %0d at %0t", db2, m2, $time);
      end
      if (o2 !== expected_outs(m2)) begin
        errors++;
        $display("FAIL model_outs_te0: got %h expected %h (state %0d) at %0t", o2, expected_outs(m2), m2, $time);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_jogada();
    jogada_feita = 1'b1;
    tick(1);
    jogada_feita = 1'b0;
  endtask

  // From inicial or a fim state: start and run up to espera_jogada.
  task automatic start_game();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    tick(1);
    fimP = 1'b1;
    tick(1);
    fimP = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; fimRod = 1'b0; fimT = 1'b0; fimP = 1'b0;
    igual = 1'b0; enderecoIgualRodada = 1'b0; jogada_feita = 1'b0;
    tick(2);
    reset = 1'b1;
    chk("reset_state", db1, 0);
    chk("reset_outs", o1, 0);

    // Start: 0 -> 1 -> 2, hold in 2 until fimP
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    chk("preparacao", db1, 1);
    chk("preparacao_zeraE", o1[15], 1);
    tick(1);
    chk("mostra_primeira", db1, 2);
    tick(3);
    chk("mostra_hold", db1, 2);
    chk("mostra_sinal_led", o1[4], 1);
    fimP = 1'b1;
    tick(1);
    fimP = 1'b0;
    chk("inicio_rodada", db1, 3);
    tick(1);
    chk("espera_jogada", db1, 4);

    // Round 0 correct play followed by a write
    igual = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b0;
    pulse_jogada();
    chk("registra", db1, 5);
    tick(3);
    chk("incrementa_endereco", db1, 9);
    tick(1);
    chk("espera_escrita", db1, 10);
    pulse_jogada();
    chk("registra_escrita", db1, 11);
    tick(1);
    chk("escreve_state", db1, 12);
    chk("escreve_we", o1[5], 1);
    tick(1);
    chk("proxima_rodada_we", o1[5], 0);
    chk("proxima_rodada_contaRod", o1[12], 1);
    tick(1);
    chk("back_inicio_rodada", db1, 3);
    tick(1);

    // Timeout in espera_escrita; TIMEOUT_EN=0 instance stays put
    pulse_jogada();
    tick(4);
    chk("espera_escrita_2", db1, 10);
    fimT = 1'b1;
    tick(1);
    chk("timeout_state", db1, 16);
    chk("timeout_flag", o1[0], 1);
    chk("no_timeout_state", db2, 10);
    tick(2);
    fimT = 1'b0;
    chk("no_timeout_hold", db2, 10);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("resync_te1", db1, 0);
    chk("resync_te0", db2, 0);

    // jogada_feita beats fimT, then a wrong play
    start_game();
    jogada_feita = 1'b1; fimT = 1'b1;
    tick(1);
    jogada_feita = 1'b0; fimT = 1'b0;
    chk("jogada_priority", db1, 5);
    igual = 1'b0;
    tick(2);
    chk("fim_errou", db1, 15);
    chk("perdeu", o1[1], 1);
    chk("perdeu_pronto", o1[3], 1);
    chk("perdeu_ganhou", o1[2], 0);
    chk("perdeu_timeout", o1[0], 0);
    igual = 1'b1;

    // Restart, correct non-final play through proximo_endereco, then win
    start_game();
    enderecoIgualRodada = 1'b0;
    pulse_jogada();
    tick(2);
    chk("proximo_endereco", db1, 7);
    chk("proximo_contaE", o1[14], 1);
    tick(1);
    chk("back_espera", db1, 4);
    enderecoIgualRodada = 1'b1; fimRod = 1'b1;
    pulse_jogada();
    tick(3);
    chk("fim_acertou", db1, 14);
    chk("ganhou", o1[2], 1);
    chk("ganhou_sinal_led", o1[4], 0);
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    chk("restart", db1, 1);

    // Mid-game reset in escreve
    tick(1);
    fimP = 1'b1;
    tick(1);
    fimP = 1'b0;
    tick(1);
    fimRod = 1'b0;
    pulse_jogada();
    tick(4);
    pulse_jogada();
    tick(1);
    chk("escreve_again", db1, 12);
    reset = 1'b0;
    tick(1);
    chk("midgame_reset_state", db1, 0);
    chk("midgame_reset_we", o1[5], 0);
    reset = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
